// File: rtl/router_fifo.sv
// Per-destination output buffer of the 1x3 router: stores header-flagged bytes from router_reg
// and tracks the bytes still outstanding in the packet currently being read out.
module router_fifo #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             soft_reset,
    input  logic             write_enb,
    input  logic             lfd_state,
    input  logic [WIDTH-1:0] data_in,
    input  logic             read_enb,
    output logic [WIDTH-1:0] data_out,
    output logic             out_valid,
    output logic             pkt_active,
    output logic             full,
    output logic             empty
);

    localparam logic [ADDR_W:0] PTR_ONE = 1;

    logic [WIDTH:0]     mem_q [DEPTH];
    logic [ADDR_W:0]    wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]    rd_ptr_q, rd_ptr_d;
    logic [6:0]         rem_cnt_q, rem_cnt_d;
    logic [WIDTH-1:0]   data_out_q, data_out_d;
    logic               out_valid_q, out_valid_d;
    logic               wr_acc, rd_acc;
    logic [WIDTH:0]     rd_entry;

    assign empty      = (wr_ptr_q == rd_ptr_q);
    assign full       = (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]) &&
                        (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]);
    assign pkt_active = (rem_cnt_q != 7'd0);
    assign data_out   = data_out_q;
    assign out_valid  = out_valid_q;

    assign wr_acc   = write_enb && !full;
    assign rd_acc   = read_enb && !empty;
    assign rd_entry = mem_q[rd_ptr_q[ADDR_W-1:0]];

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        rem_cnt_d   = rem_cnt_q;
        data_out_d  = data_out_q;
        out_valid_d = 1'b0;
        if (soft_reset) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            rem_cnt_d  = '0;
            data_out_d = '0;
        end else begin
            if (wr_acc) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (rd_acc) begin
                rd_ptr_d    = rd_ptr_q + PTR_ONE;
                data_out_d  = rd_entry[WIDTH-1:0];
                out_valid_d = 1'b1;
                // Header length field counts payload; +1 accounts for the trailing parity byte.
                if (rd_entry[WIDTH]) begin
                    rem_cnt_d = {1'b0, rd_entry[7:2]} + 7'd1;
                end else if (rem_cnt_q != 7'd0) begin
                    rem_cnt_d = rem_cnt_q - 7'd1;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            rem_cnt_q   <= '0;
            data_out_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            rem_cnt_q   <= rem_cnt_d;
            data_out_q  <= data_out_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Storage is deliberately unreset; only written locations are ever read.
    always_ff @(posedge clock) begin
        if (wr_acc && !soft_reset) begin
            mem_q[wr_ptr_q[ADDR_W-1:0]] <= {lfd_state, data_in};
        end
    end

endmodule

// File: tb/tb_router_fifo.sv
// Directed bench for router_fifo: fill/drain, overflow drop, packet byte tracking,
// concurrent read/write with wrap, soft flush and asynchronous reset.
module tb_router_fifo;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       soft_reset = 1'b0;
    logic       write_enb = 1'b0;
    logic       lfd_state = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       read_enb = 1'b0;
    logic [7:0] data_out;
    logic       out_valid, pkt_active, full, empty;

    int checks = 0;
    int errors = 0;

    router_fifo #(.WIDTH(8), .DEPTH(16), .ADDR_W(4)) dut (
        .clock(clock), .reset(reset), .soft_reset(soft_reset),
        .write_enb(write_enb), .lfd_state(lfd_state), .data_in(data_in),
        .read_enb(read_enb), .data_out(data_out), .out_valid(out_valid),
        .pkt_active(pkt_active), .full(full), .empty(empty)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [7:0] d, input logic hdr);
        write_enb = 1'b1; lfd_state = hdr; data_in = d;
        tick();
        write_enb = 1'b0; lfd_state = 1'b0;
    endtask

    task automatic rd();
        read_enb = 1'b1;
        tick();
        read_enb = 1'b0;
    endtask

    task automatic write_packet();
        wr(8'h3A, 1'b1);
        for (int i = 1; i <= 14; i++) wr(8'(i), 1'b0);
        wr(8'h35, 1'b0);
    endtask

    initial begin
        #12 reset = 1'b0;
        #1;
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_pkt_active", pkt_active, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_data_out", data_out, 0);

        // Header 3A -> length 14; payload 01..0E; parity 3A^01^..^0E = 35
        write_packet();
        check("t1_full", full, 1);
        check("t1_empty", empty, 0);

        wr(8'hFF, 1'b0);
        check("t2_still_full", full, 1);

        rd();
        check("t3_hdr_data", data_out, 8'h3A);
        check("t3_hdr_valid", out_valid, 1);
        check("t3_rem15", dut.rem_cnt_q, 15);
        check("t3_pkt_active", pkt_active, 1);
        check("t3_not_full", full, 0);
        for (int i = 1; i <= 14; i++) begin
            rd();
            check("t3_payload", data_out, i);
            check("t3_rem", dut.rem_cnt_q, 15 - i);
        end
        rd();
        check("t2_last_is_parity", data_out, 8'h35);
        check("t3_rem0", dut.rem_cnt_q, 0);
        check("t3_pkt_idle", pkt_active, 0);
        check("t2_empty_after_drain", empty, 1);
        rd();
        check("t2_rd_empty_valid", out_valid, 0);
        check("t2_rd_empty_hold", data_out, 8'h35);

        for (int i = 0; i < 16; i++) wr(8'h40 + 8'(i), 1'b0);
        check("t4_full", full, 1);
        read_enb = 1'b1; write_enb = 1'b1; data_in = 8'hEE;
        tick();
        read_enb = 1'b0; write_enb = 1'b0;
        check("t4_rw_full_data", data_out, 8'h40);
        check("t4_rw_full_valid", out_valid, 1);
        check("t4_rw_full_notfull", full, 0);
        for (int i = 1; i < 16; i++) begin
            rd();
            check("t4_drain", data_out, 8'h40 + i);
        end
        check("t4_write_dropped", empty, 1);

        for (int i = 0; i < 8; i++) wr(8'hA0 + 8'(i), 1'b0);
        for (int k = 0; k < 20; k++) begin
            read_enb = 1'b1; write_enb = 1'b1; data_in = 8'(k);
            tick();
            check("t4_conc_data", data_out, (k < 8) ? (8'hA0 + k) : (k - 8));
            check("t4_conc_valid", out_valid, 1);
            check("t4_conc_flags", {full, empty}, 2'b00);
        end
        read_enb = 1'b0; write_enb = 1'b0;

        soft_reset = 1'b1;
        tick();
        soft_reset = 1'b0;
        check("t5_pre_empty", empty, 1);
        write_packet();
        for (int i = 0; i < 5; i++) rd();
        check("t5_mid_data", data_out, 8'h04);
        check("t5_mid_rem", dut.rem_cnt_q, 11);
        soft_reset = 1'b1; write_enb = 1'b1; data_in = 8'h77;
        tick();
        soft_reset = 1'b0; write_enb = 1'b0;
        check("t5_empty", empty, 1);
        check("t5_pkt_active", pkt_active, 0);
        check("t5_out_valid", out_valid, 0);
        check("t5_data_out", data_out, 0);
        rd();
        check("t5_write_lost", out_valid, 0);
        check("t5_write_lost_empty", empty, 1);

        // Header 08 -> length 2 -> 3 bytes outstanding after header read
        wr(8'h08, 1'b1);
        wr(8'h55, 1'b0);
        rd();
        check("t6_hdr_data", data_out, 8'h08);
        check("t6_pkt_active", pkt_active, 1);
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("t6_async_data", data_out, 0);
        check("t6_async_valid", out_valid, 0);
        check("t6_async_empty", empty, 1);
        check("t6_async_pkt", pkt_active, 0);
        reset = 1'b0;
        rd();
        check("t6_post_rd_valid", out_valid, 0);
        check("t6_post_rd_empty", empty, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
